// File: rtl/id_decode_stage.sv
// Instruction-decode stage: IF/ID latch, 32x64 register file with write-back bypass,
// immediate generator, main control decoder and load-use hazard detection.
module id_decode_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned NREGS     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  input  logic            wb_regwrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_memread,
  input  logic [4:0]      ex_rd,
  output logic            pc_write,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic [XLEN-1:0] imm_data,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [3:0]      Funct,
  output logic [1:0]      ALUOp,
  output logic            ALUSrc,
  output logic            Branch,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic            MemtoReg,
  output logic            illegal
);

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpIAlu = 7'b0010011;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSd   = 7'b0100011;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  // IF/ID pipeline latch
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  // Cleared by reset/flush so the injected NOP decodes as a pure bubble.
  logic            ifid_valid_q, ifid_valid_d;

  logic [XLEN-1:0] regs_q [NREGS];

  logic [6:0] opcode;
  logic       stall;
  logic       uses_rs2;

  // Decoded control before bubble gating
  logic       dec_alusrc;
  logic       dec_branch;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_regwrite;
  logic       dec_memtoreg;
  logic [1:0] dec_aluop;
  logic       dec_illegal;

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  assign opcode = ifid_instr_q[6:0];
  assign rs1    = ifid_instr_q[19:15];
  assign rs2    = ifid_instr_q[24:20];
  assign rd     = ifid_instr_q[11:7];
  assign Funct  = {ifid_instr_q[30], ifid_instr_q[14:12]};
  assign PC     = ifid_pc_q;

  // ---------------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    uses_rs2 = (opcode == OpR) || (opcode == OpSd) || (opcode == OpBeq);
    stall    = ex_memread && (ex_rd != 5'd0) &&
               ((ex_rd == rs1) || ((ex_rd == rs2) && uses_rs2));
    // A flush redirects the PC anyway, so it overrides the hold.
    pc_write = !stall || flush;
  end

  // ---------------------------------------------------------------------------
  // IF/ID latch
  // ---------------------------------------------------------------------------
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (flush) begin
      ifid_pc_d    = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      ifid_pc_d    = if_pc;
      ifid_instr_d = if_instr;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_regwrite && (wb_rd != 5'd0)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Write-back data is forwarded so the same-cycle reader sees it.
  always_comb begin
    if (rs1 == 5'd0) begin
      ReadData1 = '0;
    end else if (wb_regwrite && (wb_rd == rs1)) begin
      ReadData1 = wb_data;
    end else begin
      ReadData1 = regs_q[rs1];
    end
  end

  always_comb begin
    if (rs2 == 5'd0) begin
      ReadData2 = '0;
    end else if (wb_regwrite && (wb_rd == rs2)) begin
      ReadData2 = wb_data;
    end else begin
      ReadData2 = regs_q[rs2];
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate generator
  // ---------------------------------------------------------------------------
  always_comb begin
    imm_data = '0;
    case (opcode)
      OpIAlu, OpLd: begin
        imm_data = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31:20]};
      end
      OpSd: begin
        imm_data = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
      end
      OpBeq: begin
        // Branch offset left unshifted; EX applies the <<1.
        imm_data = {{(XLEN-12){ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                    ifid_instr_q[30:25], ifid_instr_q[11:8]};
      end
      default: imm_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main control decoder
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_aluop    = 2'b00;
    dec_illegal  = 1'b0;
    case (opcode)
      OpR: begin
        dec_regwrite = 1'b1;
        dec_aluop    = 2'b10;
      end
      OpIAlu: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
      end
      OpLd: begin
        dec_alusrc   = 1'b1;
        dec_memread  = 1'b1;
        dec_regwrite = 1'b1;
        dec_memtoreg = 1'b1;
      end
      OpSd: begin
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OpBeq: begin
        dec_branch = 1'b1;
        dec_aluop  = 2'b01;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Bubble: a stall or an injected NOP drives all control to zero.
  always_comb begin
    if (ifid_valid_q && !stall) begin
      ALUSrc   = dec_alusrc;
      Branch   = dec_branch;
      MemRead  = dec_memread;
      MemWrite = dec_memwrite;
      RegWrite = dec_regwrite;
      MemtoReg = dec_memtoreg;
      ALUOp    = dec_aluop;
    end else begin
      ALUSrc   = 1'b0;
      Branch   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      MemtoReg = 1'b0;
      ALUOp    = 2'b00;
    end
    illegal = ifid_valid_q && dec_illegal;
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the decode stage.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        pc_write;
  logic [63:0] PC, ReadData1, ReadData2, imm_data;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  Funct;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk        (clk),
    .reset      (reset),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .flush      (flush),
    .wb_regwrite(wb_regwrite),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .pc_write   (pc_write),
    .PC         (PC),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .imm_data   (imm_data),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .Funct      (Funct),
    .ALUOp      (ALUOp),
    .ALUSrc     (ALUSrc),
    .Branch     (Branch),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .illegal    (illegal)
  );

  // Behavioural model state: architectural registers plus the instruction sitting in ID.
  logic [63:0] m_regs [32];
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_real;  // 0 when ID holds a reset/flush-injected NOP

  // Expected outputs
  logic        e_stall, e_pc_write, e_illegal;
  logic [63:0] e_rd1, e_rd2, e_imm;
  logic [7:0]  e_ctrl;  // {ALUSrc,Branch,MemRead,MemWrite,RegWrite,MemtoReg,ALUOp}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 64'd0;
    if (wb_regwrite && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic [63:0] sext12(input logic [11:0] f);
    longint v;
    v = longint'(f);
    if (f[11]) v = v - 4096;
    return 64'(v);
  endfunction

  task automatic model_outputs();
    logic [6:0] op;
    logic [4:0] s1, s2;
    logic       rs2_used;
    logic [7:0] ctrl;
    logic       unknown;
    op = m_instr[6:0];
    s1 = m_instr[19:15];
    s2 = m_instr[24:20];
    unknown = 1'b0;
    e_imm = 64'd0;
    case (op)
      7'b0110011: ctrl = 8'b0000_1010;
      7'b0010011: begin ctrl = 8'b1000_1000; e_imm = sext12(m_instr[31:20]); end
      7'b0000011: begin ctrl = 8'b1010_1100; e_imm = sext12(m_instr[31:20]); end
      7'b0100011: begin ctrl = 8'b1001_0000; e_imm = sext12({m_instr[31:25], m_instr[11:7]}); end
      7'b1100011: begin
        ctrl  = 8'b0100_0001;
        e_imm = sext12({m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8]});
      end
      default: begin ctrl = 8'b0; unknown = 1'b1; end
    endcase
    rs2_used   = (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    e_stall    = ex_memread && ex_rd != 0 && (ex_rd == s1 || (rs2_used && ex_rd == s2));
    e_pc_write = !e_stall || flush;
    e_ctrl     = (m_real && !e_stall) ? ctrl : 8'b0;
    e_illegal  = m_real && unknown;
    e_rd1      = model_read(s1);
    e_rd2      = model_read(s2);
  endtask

  task automatic model_check();
    model_outputs();
    chk("pc_write", 64'(pc_write), 64'(e_pc_write));
    chk("PC", PC, m_pc);
    chk("ReadData1", ReadData1, e_rd1);
    chk("ReadData2", ReadData2, e_rd2);
    chk("imm_data", imm_data, e_imm);
    chk("rs1", 64'(rs1), 64'(m_instr[19:15]));
    chk("rs2", 64'(rs2), 64'(m_instr[24:20]));
    chk("rd", 64'(rd), 64'(m_instr[11:7]));
    chk("Funct", 64'(Funct), 64'({m_instr[30], m_instr[14:12]}));
    chk("ctrl", 64'({ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp}), 64'(e_ctrl));
    chk("illegal", 64'(illegal), 64'(e_illegal));
  endtask

  // Wait to mid-cycle and compare against the model.
  task automatic tick_check();
    @(negedge clk);
    model_check();
  endtask

  // Clock edge: update the model from the inputs present at the edge.
  task automatic advance();
    @(posedge clk);
    model_outputs();
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_pc = 64'd0; m_instr = 32'h0000_0013; m_real = 1'b0;
    end else begin
      if (wb_regwrite && wb_rd != 0) m_regs[wb_rd] = wb_data;
      if (flush) begin
        m_pc = 64'd0; m_instr = 32'h0000_0013; m_real = 1'b0;
      end else if (!e_stall) begin
        m_pc = if_pc; m_instr = if_instr; m_real = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [5];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011;
    r = $urandom;
    r[24:20] = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 6) < 5) r[6:0] = ops[$urandom_range(0, 4)];
    return r;
  endfunction

  initial begin
    reset = 1'b0; if_pc = 64'd0; if_instr = 32'h0000_0013; flush = 1'b0;
    wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 64'd0; ex_memread = 1'b0; ex_rd = 5'd0;
    advance();
    reset = 1'b1;

    // Reset state decodes a bubble
    tick_check();
    chk("rst_ctrl", 64'({ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, ALUOp}), 64'd0);
    chk("rst_PC", PC, 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_pc_write", 64'(pc_write), 64'd1);

    // add x1,x5,x0: x5 reads 0 after reset
    if_instr = 32'h0002_80B3; if_pc = 64'h100;
    advance();
    tick_check();
    chk("x5_after_reset", ReadData1, 64'd0);
    chk("add_regwrite", 64'(RegWrite), 64'd1);
    // Same instruction again, now with write-back of x5 in the decode cycle
    advance();
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF;
    tick_check();
    chk("bypass_x5", ReadData1, 64'hDEAD_BEEF);
    chk("bypass_pc", PC, 64'h100);

    // Write x0=7, decode add x1,x0,x0
    if_instr = 32'h0000_00B3;
    advance();
    wb_rd = 5'd0; wb_data = 64'd7;
    tick_check();
    chk("x0_reads_zero", ReadData1, 64'd0);

    // ld x5,-8(x2)
    if_instr = 32'hFF81_3283; if_pc = 64'h108;
    advance();
    wb_regwrite = 1'b0;
    tick_check();
    chk("ld_imm", imm_data, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ld_ctrl", 64'({ALUSrc, MemRead, RegWrite, MemtoReg}), 64'hF);

    // Load-use stall on add x6,x5,x7
    if_instr = 32'h0072_8333; if_pc = 64'h200;
    advance();
    ex_memread = 1'b1; ex_rd = 5'd5; if_instr = 32'h0010_0093; if_pc = 64'h204;
    tick_check();
    chk("stall_pc_write", 64'(pc_write), 64'd0);
    chk("stall_regwrite", 64'(RegWrite), 64'd0);
    advance();
    tick_check();
    chk("stall_hold_pc", PC, 64'h200);
    advance();
    ex_memread = 1'b0;
    tick_check();
    chk("unstall_pc", PC, 64'h200);
    chk("unstall_regwrite", 64'(RegWrite), 64'd1);
    chk("unstall_aluop", 64'(ALUOp), 64'd2);

    // Flush while stalled
    if_instr = 32'h0072_8333; if_pc = 64'h300;
    advance();
    ex_memread = 1'b1; ex_rd = 5'd5; flush = 1'b1;
    tick_check();
    chk("flush_pc_write", 64'(pc_write), 64'd1);
    chk("flush_bubble", 64'(RegWrite), 64'd0);
    advance();
    flush = 1'b0; ex_memread = 1'b0;
    tick_check();
    chk("flush_PC", PC, 64'd0);
    chk("flush_rd", 64'(rd), 64'd0);

    // beq x1,x2,-4 then an unsupported opcode
    if_instr = 32'hFE20_8EE3; if_pc = 64'h400;
    advance();
    tick_check();
    chk("beq_branch", 64'(Branch), 64'd1);
    chk("beq_aluop", 64'(ALUOp), 64'd1);
    chk("beq_imm", imm_data, 64'hFFFF_FFFF_FFFF_FFFE);
    if_instr = 32'h0000_007F;
    advance();
    tick_check();
    chk("illegal_op", 64'(illegal), 64'd1);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      advance();
      reset       = ($urandom_range(0, 63) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 7));
      wb_regwrite = 1'($urandom);
      wb_rd       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wb_data     = {$urandom, $urandom};
      if_pc       = {$urandom, $urandom};
      if_instr    = rand_instr();
      tick_check();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
